// File: rtl/clk_enable_gen_pkg.sv
// Shared types and constants for the clk_enable_gen clock-enable generator.
`timescale 1ns/1ps
package clk_enable_gen_pkg;

  localparam int unsigned DEFAULT_DIV = 2;

  typedef enum logic {
    CONT    = 1'b0,
    ONESHOT = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/clk_enable_ch.sv
// One clock-enable channel: period counter, IDLE/RUN state and pending config.
// One-shot mode and trigger-start exist only when CLK_ENABLE_GEN_ONESHOT_EN is defined.
`timescale 1ns/1ps
module clk_enable_ch
  import clk_enable_gen_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned RST_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic             trig,
  output logic             enable,
  output logic             busy
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, pmode_q, pmode_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] last;
  logic             terminal;
  logic             apply;

  // Periods of 0 and 1 both collapse to a terminal count of 0.
  assign last     = (div_q > DIV_W'(1)) ? div_q - DIV_W'(1) : '0;
  assign terminal = (state_q == RUN) && (cnt_q == last);
  assign enable   = terminal && en;

`ifdef CLK_ENABLE_GEN_ONESHOT_EN
  assign busy = (state_q == RUN);
`else
  assign busy = 1'b1;
  logic unused_cfg_mode;
  assign unused_cfg_mode = cfg_mode;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mode_q  <= CONT;
      cnt_q   <= '0;
      div_q   <= DIV_W'(RST_DIV);
      pdiv_q  <= '0;
      pmode_q <= CONT;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pmode_q <= pmode_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    pmode_d = pmode_q;
    pend_d  = pend_q;
    apply   = 1'b0;

    if (en) begin
      case (state_q)
        RUN: begin
          // A continuous-mode trigger realigns phase and cancels this boundary.
          if (trig && (mode_q == CONT)) begin
            cnt_d = '0;
          end else if (terminal) begin
            cnt_d = '0;
            apply = pend_q;
            if (mode_q == ONESHOT) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        IDLE: begin
          if (pend_q) begin
            apply = 1'b1;
          end
`ifdef CLK_ENABLE_GEN_ONESHOT_EN
          else if (trig) begin
            state_d = RUN;
            cnt_d   = '0;
          end
`endif
        end
        default: state_d = RUN;
      endcase
    end

    if (apply) begin
      div_d   = pdiv_q;
      mode_d  = pmode_q;
      pend_d  = 1'b0;
      cnt_d   = '0;
      state_d = (pmode_q == CONT) ? RUN : IDLE;
    end

    // Captured after apply so a write on a boundary waits for the next one.
    if (cfg_wr) begin
      pdiv_d = cfg_div;
`ifdef CLK_ENABLE_GEN_ONESHOT_EN
      pmode_d = mode_e'(cfg_mode);
`else
      pmode_d = CONT;
`endif
      pend_d = 1'b1;
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator: config decode and iEn fan-out.
// Optional one-shot mode is enabled by defining CLK_ENABLE_GEN_ONESHOT_EN.
`timescale 1ns/1ps
module clk_enable_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = clk_enable_gen_pkg::DEFAULT_DIV,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iEn,
  input  logic              iCfgWr,
  input  logic [CH_W-1:0]   iCfgCh,
  input  logic [DIV_W-1:0]  iCfgDiv,
  input  logic              iCfgMode,
  input  logic [NUM_CH-1:0] iTrig,
  output logic [NUM_CH-1:0] oEnable,
  output logic [NUM_CH-1:0] oBusy
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr;

    // Out-of-range channel numbers match no instance and are dropped.
    assign wr = iCfgWr && (iCfgCh == CH_W'(g));

    clk_enable_ch #(
      .DIV_W  (DIV_W),
      .RST_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk     (iClk),
      .rst_n   (iRsn),
      .en      (iEn),
      .cfg_wr  (wr),
      .cfg_div (iCfgDiv),
      .cfg_mode(iCfgMode),
      .trig    (iTrig[g]),
      .enable  (oEnable[g]),
      .busy    (oBusy[g])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: countdown reference model plus literal pins.
`timescale 1ns/1ps
module tb_clk_enable_gen;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CH_W   = 2;
`ifdef CLK_ENABLE_GEN_ONESHOT_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_mode = 1'b0;
  logic [NUM_CH-1:0] trig = '0;
  logic [NUM_CH-1:0] enable, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_enable_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(2)) dut (
    .iClk(clk), .iRsn(rst_n), .iEn(en), .iCfgWr(cfg_wr), .iCfgCh(cfg_ch),
    .iCfgDiv(cfg_div), .iCfgMode(cfg_mode), .iTrig(trig),
    .oEnable(enable), .oBusy(busy)
  );

  // Reference model: m_rem = enabled cycles left until the pulse (pulse when 1).
  bit m_run [NUM_CH];
  bit m_os  [NUM_CH];
  int m_per [NUM_CH];
  int m_rem [NUM_CH];
  bit m_pend[NUM_CH];
  int m_pdiv[NUM_CH];
  bit m_pmod[NUM_CH];
  int cyc;
  logic [NUM_CH-1:0] hist_en  [0:63];
  logic [NUM_CH-1:0] hist_busy[0:63];

  function automatic int period(int d);
    return (d < 2) ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 1'b1; m_os[c] = 1'b0; m_per[c] = 2; m_rem[c] = 2;
      m_pend[c] = 1'b0; m_pdiv[c] = 0; m_pmod[c] = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic model_apply(int c);
    m_per[c]  = period(m_pdiv[c]);
    m_os[c]   = m_pmod[c];
    m_run[c]  = !m_pmod[c];
    m_rem[c]  = m_per[c];
    m_pend[c] = 1'b0;
  endtask

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      if (en) begin
        if (m_run[c]) begin
          if (trig[c] && !m_os[c]) m_rem[c] = m_per[c];
          else if (m_rem[c] == 1) begin
            if (m_pend[c]) model_apply(c);
            else begin
              if (m_os[c]) m_run[c] = 1'b0;
              m_rem[c] = m_per[c];
            end
          end else m_rem[c]--;
        end else begin
          if (m_pend[c]) model_apply(c);
          else if (trig[c] && OS) begin
            m_run[c] = 1'b1;
            m_rem[c] = m_per[c];
          end
        end
      end
      if (cfg_wr && (int'(cfg_ch) == c)) begin
        m_pend[c] = 1'b1;
        m_pdiv[c] = int'(cfg_div);
        m_pmod[c] = cfg_mode & OS;
      end
    end
  endtask

  task automatic chk(string name, logic [NUM_CH-1:0] got, logic [NUM_CH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc + 1, got, exp);
    end
  endtask

  task automatic chk_bit(string name, int cy, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cy, got, exp);
    end
  endtask

  // Compare process: DUT against model every cycle, mid-period.
  always @(negedge clk) begin
    logic [NUM_CH-1:0] exp_en, exp_busy;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_en[c]   = rst_n && en && m_run[c] && (m_rem[c] == 1);
      exp_busy[c] = OS ? m_run[c] : 1'b1;
    end
    chk("oEnable", enable, exp_en);
    chk("oBusy", busy, exp_busy);
    if (cyc + 1 < 64) begin
      hist_en[cyc + 1]   = enable;
      hist_busy[cyc + 1] = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step();
      cyc++;
    end
    #1;
    cfg_wr = 1'b0;
    trig   = '0;
  endtask

  task automatic at_cycle(int n);
    while (cyc < n - 1) tick();
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_wr(int c, int d, bit m);
    cfg_wr   = 1'b1;
    cfg_ch   = CH_W'(c);
    cfg_div  = DIV_W'(d);
    cfg_mode = m;
  endtask

  initial begin
    model_reset();
    en = 1'b1;
    do_reset(2);

    // Phase 1: default pulses, ch1 reprogram mid-period, ch2 one-shot.
    at_cycle(3);  set_wr(1, 5, 1'b0); tick();
    at_cycle(5);  set_wr(2, 3, 1'b1); tick();
    at_cycle(10); trig[2] = 1'b1; tick();
    at_cycle(12); trig[2] = 1'b1; tick();
    at_cycle(21);
    chk("reset_pattern_c1", hist_en[1], 4'h0);
    chk("reset_pattern_c2", hist_en[2], 4'hF);
    chk("reset_pattern_c3", hist_en[3], 4'h0);
    chk("reset_pattern_c4", hist_en[4], 4'hF);
    chk("reset_busy", hist_busy[1], 4'hF);
    chk_bit("ch1_no_pulse_6", 6, hist_en[6][1], 1'b0);
    chk_bit("ch1_pulse_9", 9, hist_en[9][1], 1'b1);
    chk_bit("ch1_no_pulse_11", 11, hist_en[11][1], 1'b0);
    chk_bit("ch1_pulse_14", 14, hist_en[14][1], 1'b1);
    chk_bit("ch1_pulse_19", 19, hist_en[19][1], 1'b1);
    chk_bit("ch0_pulse_6", 6, hist_en[6][0], 1'b1);
    chk_bit("ch0_no_pulse_7", 7, hist_en[7][0], 1'b0);
    if (OS) begin
      chk_bit("ch2_os_idle_12", 12, hist_en[12][2], 1'b0);
      chk_bit("ch2_os_pulse_13", 13, hist_en[13][2], 1'b1);
      chk_bit("ch2_os_no_pulse_15", 15, hist_en[15][2], 1'b0);
      chk_bit("ch2_busy_10", 10, hist_busy[10][2], 1'b0);
      chk_bit("ch2_busy_11", 11, hist_busy[11][2], 1'b1);
      chk_bit("ch2_busy_13", 13, hist_busy[13][2], 1'b1);
      chk_bit("ch2_busy_14", 14, hist_busy[14][2], 1'b0);
    end

    // Phase 2: iEn freeze on ch0 div 4, then ch3 div 0 and div 1.
    do_reset(1);
    set_wr(0, 4, 1'b0); tick();
    at_cycle(5);  en = 1'b0;
    at_cycle(9);  en = 1'b1;
    at_cycle(11); set_wr(3, 0, 1'b0); tick();
    at_cycle(16); set_wr(3, 1, 1'b0); tick();
    at_cycle(23);
    chk_bit("ch0_no_pulse_6", 6, hist_en[6][0], 1'b0);
    chk_bit("ch0_delayed_10", 10, hist_en[10][0], 1'b1);
    chk_bit("ch0_pulse_14", 14, hist_en[14][0], 1'b1);
    chk("frozen_c5", hist_en[5], 4'h0);
    chk("frozen_c8", hist_en[8], 4'h0);
    for (int k = 13; k <= 22; k++) chk_bit("ch3_every_cycle", k, hist_en[k][3], 1'b1);

    // Phase 3: reset while ch2 one-shot runs with a pending write.
    do_reset(1);
    set_wr(2, 3, 1'b1); tick();
    at_cycle(4); trig[2] = 1'b1; tick();
    at_cycle(5); set_wr(2, 9, 1'b0); tick();
    at_cycle(6);
    @(negedge clk);
    #1;
    if (OS) chk_bit("ch2_busy_before_reset", 6, hist_busy[6][2], 1'b1);
    do_reset(1);
    at_cycle(7);
    chk_bit("ch2_after_reset_c2", 2, hist_en[2][2], 1'b1);
    chk_bit("ch2_after_reset_c3", 3, hist_en[3][2], 1'b0);
    chk_bit("ch2_after_reset_c4", 4, hist_en[4][2], 1'b1);
    chk_bit("ch2_after_reset_c6", 6, hist_en[6][2], 1'b1);
    chk("busy_after_reset", hist_busy[5], 4'hF);

    // Phase 4: randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(2);
      end else begin
        en = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 4) == 0)
          set_wr(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 9)),
                 1'($urandom_range(0, 1)));
        for (int c = 0; c < NUM_CH; c++) trig[c] = ($urandom_range(0, 11) == 0);
        tick();
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Multi-channel, run-time programmable clock-enable generator. It is the parametrised successor of the fixed divide-by-2 enable counter. Each channel produces a one-cycle enable pulse every N cycles of the single system clock, in either continuous or one-shot mode. Downstream blocks (UART baud ticks, scan timers, sample strobes) consume `oEnable[ch]` as a clock qualifier rather than a derived clock.

## Interface
- `NUM_CH`, 4, number of independent channels (1..16)
- `DIV_W`, 8, width of the period value
- `DEFAULT_DIV`, 2, reset period of every channel (must fit `DIV_W`)
- `iClk`  in  1  system clock, all logic on rising edge
- `iRsn`  in  1  asynchronous active-low reset
- `iEn`  in  1  global enable; low freezes all counters and forces `oEnable` low
- `iCfgWr`  in  1  configuration write strobe, one cycle
- `iCfgCh`  in  `$clog2(NUM_CH)` (min 1)  target channel of the write; out-of-range is ignored
- `iCfgDiv`  in  `DIV_W`  new period in cycles
- `iCfgMode`  in  1  0 = continuous, 1 = one-shot
- `iTrig`  in  `NUM_CH`  per-channel start / phase-align strobe
- `oEnable`  out  `NUM_CH`  per-channel enable pulse
- `oBusy`  out  `NUM_CH`  channel in RUN state

## Operation
- Per-channel state: IDLE, RUN. Per-channel registers:
  - `cnt[DIV_W]`
  - active period `div` and mode
  - pending period/mode plus pending-valid bit
- Effective period P = `div`. `div` of 0 or 1 means P = 1, so `oEnable` stays high every cycle while running.
- RUN: `cnt` increments each cycle when `iEn` = 1. At `cnt == P-1` (terminal), `oEnable` = 1 and `cnt` wraps to 0.
- `oEnable[ch]` = RUN & terminal & `iEn`. It is decoded from registers and gated combinationally by `iEn` only.
- Continuous mode:
  - stays in RUN.
  - `iTrig[ch]` clears `cnt` to 0 (phase realignment); terminal is suppressed in that cycle.
- One-shot mode:
  - IDLE → RUN on `iTrig[ch]`, with `cnt` cleared.
  - RUN → IDLE after the terminal cycle, so exactly one pulse, P cycles after the trigger.
  - `iTrig` while in RUN is ignored.
- Config write:
  - `iCfgWr` loads pending (div, mode) and sets pending-valid. A second write before apply overwrites it.
  - Apply happens at the next terminal cycle of that channel, or in the next cycle if the channel is IDLE. Apply clears pending-valid and `cnt`.
  - A write in the same cycle as a terminal is applied at the following boundary, never the current one.
  - Switching to continuous while IDLE moves the channel to RUN on apply.
  - Switching to one-shot on apply moves it to IDLE.
- `iEn` low: no counting, no state changes, no apply. Config writes are still captured into pending.

## Timing
- Reset values:
  - `cnt` = 0, `div` = `DEFAULT_DIV`, mode continuous, state RUN, pending-valid = 0
  - `oEnable` = 0, `oBusy` = all ones
- After reset release with `DEFAULT_DIV` = 2: `oEnable` is high in cycles 2, 4, 6 … (counting the first rising edge as cycle 1).
- Config latency:
  - IDLE channel: 1 cycle.
  - RUN channel: up to P cycles, so no period is ever truncated.
- One-shot: pulse in cycle T+P, where T is the trigger cycle. `oBusy` is high in cycles T+1 … T+P.
- Reset mid-operation: immediate return to reset values. Pending config is discarded.

## Configuration
- `CLK_ENABLE_GEN_ONESHOT_EN` defined: one-shot mode, the IDLE state, and the trigger-start behaviour are present.
- Undefined:
  - `iCfgMode` is ignored and every channel is always continuous.
  - `iTrig` only performs phase realignment.
  - `oBusy` is tied high.

## Structure
- Package `clk_enable_gen_pkg`: mode enum (CONT, ONESHOT), state enum (IDLE, RUN), `DEFAULT_DIV` constant.
- Sub-module `clk_enable_ch`: one channel (counter, state, pending register), instantiated `NUM_CH` times in a generate loop.
- The top level holds only the channel decode and `iEn` fan-out.

## Test plan
- Reset, `iEn` = 1, no writes → every `oEnable[ch]` high in cycles 2, 4, 6; `oBusy` = 4'hF.
- Write ch1 `div` = 5 at cycle 3 (mid-period) → ch1 completes its current period-2 pulse at cycle 4, then pulses at 9, 14, 19; other channels unchanged.
- Write ch2 one-shot `div` = 3, then `iTrig[2]` at cycle 10 → single pulse at cycle 13, `oBusy[2]` high for cycles 11–13 only; a second `iTrig[2]` at cycle 12 is ignored.
- `iEn` low for cycles 5–8 on ch0 `div` = 4 → no pulses in that window; counting resumes from the frozen `cnt`, and the next pulse is delayed by exactly 4 cycles.
- Write ch3 `div` = 0 → after apply, `oEnable[3]` high every cycle; write `div` = 1 → identical behaviour.
- Assert `iRsn` low while ch2 one-shot is in RUN with a pending write → after release, ch2 is continuous with `div` = 2 and the pending value is lost.
